sync_fifo_ctrl: RTL and testbench

Single-clock, parametrised successor to the team's dual-clock FIFO, for intra-domain buffering on the RFSoC controller datapath. It adds the following features:
- selectable standard or first-word-fall-through (FWFT) read mode;
- occupancy count output;
- programmable almost-full and almost-empty flags;
- sticky overflow and underflow error flags.

Storage is a simple dual-port RAM written and read on the same clock edge domain.

---
 rtl/sync_fifo_ctrl_pkg.sv | 29 ++
 rtl/sync_fifo_ctrl_if.sv | 37 +++
 rtl/sync_fifo_ctrl_dpram.sv | 41 ++++
 rtl/sync_fifo_ctrl.sv | 135 +++++++++++++
 tb/tb_sync_fifo_ctrl.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/sync_fifo_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// fifo_pkg : shared types, constants and parameter checks for sync_fifo_ctrl
// Revision : 1.0
// ============================================================================
package fifo_pkg;

  // One bit above the address width lets the count reach FIFO_DEPTH exactly.
  localparam int COUNT_GUARD_BITS = 1;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  function automatic int count_width(input int aw);
    return aw + COUNT_GUARD_BITS;
  endfunction

  function automatic bit depth_ok(input int depth, input int aw);
    return (aw >= 1) && (depth == (1 << aw));
  endfunction

  function automatic bit thresholds_ok(input int depth, input int ae, input int af);
    return (ae >= 0) && (ae < af) && (af <= depth);
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
// sync_fifo_ctrl_if : write/read handshake and status bundle of sync_fifo_ctrl
// Revision : 1.0
// ============================================================================
interface sync_fifo_ctrl_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4
);
  logic [DATA_WIDTH-1:0]                   Data_in;
  logic                                    WriteEn_in;
  logic                                    ReadEn_in;
  logic [DATA_WIDTH-1:0]                   Data_out;
  logic                                    Full_out;
  logic                                    AlmostFull_out;
  logic                                    Empty_out;
  logic                                    AlmostEmpty_out;
  logic                                    Valid_out;
  logic [count_width(ADDRESS_WIDTH)-1:0]   Count_out;
  logic                                    Overflow_out;
  logic                                    Underflow_out;

  modport master (
    output Data_in, WriteEn_in, ReadEn_in,
    input  Data_out, Full_out, AlmostFull_out, Empty_out, AlmostEmpty_out,
           Valid_out, Count_out, Overflow_out, Underflow_out
  );

  modport slave (
    input  Data_in, WriteEn_in, ReadEn_in,
    output Data_out, Full_out, AlmostFull_out, Empty_out, AlmostEmpty_out,
           Valid_out, Count_out, Overflow_out, Underflow_out
  );
endinterface
`default_nettype wire

// File: rtl/sync_fifo_ctrl_dpram.sv
`default_nettype none
// ============================================================================
// fifo_dpram : simple dual-port RAM, one write port, one registered read port
// Revision : 1.0
// ============================================================================
module fifo_dpram #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     wr_en,
  input  wire logic [ADDRESS_WIDTH-1:0] wr_addr,
  input  wire logic [DATA_WIDTH-1:0]    wr_data,
  input  wire logic                     rd_en,
  input  wire logic [ADDRESS_WIDTH-1:0] rd_addr,
  output logic      [DATA_WIDTH-1:0]    rd_data
);
  localparam int DEPTH = 1 << ADDRESS_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_d, rd_data_q;

  // Read register holds its word until the next enabled read.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem_q[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;
endmodule
`default_nettype wire

// File: rtl/sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// sync_fifo_ctrl : single-clock FIFO controller, standard or FWFT read,
//                  occupancy count, almost flags and sticky error flags
// Revision : 1.0
// ============================================================================
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH          = 8,
  parameter int ADDRESS_WIDTH       = 4,
  parameter int FIFO_DEPTH          = 1 << ADDRESS_WIDTH,
  parameter int FWFT                = 0,
  parameter int ALMOST_FULL_THRESH  = FIFO_DEPTH - 2,
  parameter int ALMOST_EMPTY_THRESH = 2
) (
  input wire logic        Clk,
  input wire logic        Clear_in,
  sync_fifo_ctrl_if.slave bus
);
  localparam int         CW   = count_width(ADDRESS_WIDTH);
  localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

  typedef logic [CW-1:0]            count_t;
  typedef logic [ADDRESS_WIDTH-1:0] ptr_t;

  generate
    if (!depth_ok(FIFO_DEPTH, ADDRESS_WIDTH) ||
        !thresholds_ok(FIFO_DEPTH, ALMOST_EMPTY_THRESH, ALMOST_FULL_THRESH)) begin : g_param_check
      $fatal(1, "sync_fifo_ctrl: invalid depth or almost-flag thresholds");
    end
  endgenerate

  ptr_t                  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  count_t                count_q, count_d;
  logic                  full_q, full_d, afull_q, afull_d;
  logic                  empty_q, empty_d, aempty_q, aempty_d;
  logic                  valid_q, valid_d, ovf_q, ovf_d, udf_q, udf_d;
  logic                  sel_ram_q, sel_ram_d;
  logic [DATA_WIDTH-1:0] byp_q, byp_d, ram_rdata;
  logic                  wr_acc, rd_acc, ram_we, ram_re, head_free, ram_nz;

  always_comb begin
    wr_acc  = bus.WriteEn_in & ~full_q;
    rd_acc  = bus.ReadEn_in & ~empty_q;
    count_d = count_q;
    if (wr_acc && !rd_acc)      count_d = count_q + count_t'(1);
    else if (rd_acc && !wr_acc) count_d = count_q - count_t'(1);
    full_d   = (count_d == count_t'(FIFO_DEPTH));
    afull_d  = (count_d >= count_t'(ALMOST_FULL_THRESH));
    empty_d  = (count_d == '0);
    aempty_d = (count_d <= count_t'(ALMOST_EMPTY_THRESH));
    ovf_d    = ovf_q | (bus.WriteEn_in & full_q);
    udf_d    = udf_q | (bus.ReadEn_in & empty_q);
  end

  // In FWFT mode the output register is the head slot; the RAM holds the rest.
  always_comb begin
    head_free = rd_acc | empty_q;
    ram_nz    = (count_q > count_t'(1));
    ram_we    = wr_acc;
    ram_re    = rd_acc;
    byp_d     = byp_q;
    sel_ram_d = sel_ram_q;
    valid_d   = rd_acc;
    if (MODE == FIFO_FWFT) begin
      ram_re = head_free & ram_nz;
      ram_we = wr_acc & ~(head_free & ~ram_nz);
      if (head_free && !ram_nz && wr_acc) begin
        byp_d     = bus.Data_in;
        sel_ram_d = 1'b0;
      end else if (ram_re) begin
        sel_ram_d = 1'b1;
      end
      valid_d = (count_d != '0);
    end
    wr_ptr_d = ram_we ? wr_ptr_q + ptr_t'(1) : wr_ptr_q;
    rd_ptr_d = ram_re ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;
  end

  always_ff @(posedge Clk) begin
    if (Clear_in) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      afull_q   <= 1'b0;
      empty_q   <= 1'b1;
      aempty_q  <= 1'b1;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      sel_ram_q <= 1'b0;
      byp_q     <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      afull_q   <= afull_d;
      empty_q   <= empty_d;
      aempty_q  <= aempty_d;
      valid_q   <= valid_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      sel_ram_q <= sel_ram_d;
      byp_q     <= byp_d;
    end
  end

  fifo_dpram #(
    .DATA_WIDTH    (DATA_WIDTH),
    .ADDRESS_WIDTH (ADDRESS_WIDTH)
  ) u_ram (
    .clk     (Clk),
    .rst     (Clear_in),
    .wr_en   (ram_we),
    .wr_addr (wr_ptr_q),
    .wr_data (bus.Data_in),
    .rd_en   (ram_re),
    .rd_addr (rd_ptr_q),
    .rd_data (ram_rdata)
  );

  assign bus.Data_out        = (MODE == FIFO_FWFT && !sel_ram_q) ? byp_q : ram_rdata;
  assign bus.Valid_out       = valid_q;
  assign bus.Count_out       = count_q;
  assign bus.Full_out        = full_q;
  assign bus.AlmostFull_out  = afull_q;
  assign bus.Empty_out       = empty_q;
  assign bus.AlmostEmpty_out = aempty_q;
  assign bus.Overflow_out    = ovf_q;
  assign bus.Underflow_out   = udf_q;
endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// tb_sync_fifo_ctrl : standard and FWFT instances driven in lockstep against a
//                     queue-based reference model with a read-data scoreboard
// Revision : 1.0
// ============================================================================
module tb_sync_fifo_ctrl;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic Clk = 1'b0;
  logic Clear_in;
  always #5 Clk = ~Clk;

  sync_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus_std ();
  sync_fifo_ctrl_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus_fwft ();

  sync_fifo_ctrl #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .FIFO_DEPTH(DEPTH), .FWFT(0),
    .ALMOST_FULL_THRESH(AF), .ALMOST_EMPTY_THRESH(AE)
  ) u_std (.Clk(Clk), .Clear_in(Clear_in), .bus(bus_std));

  sync_fifo_ctrl #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .FIFO_DEPTH(DEPTH), .FWFT(1),
    .ALMOST_FULL_THRESH(AF), .ALMOST_EMPTY_THRESH(AE)
  ) u_fwft (.Clk(Clk), .Clear_in(Clear_in), .bus(bus_fwft));

  // Reference model: contents as a queue, sticky flags, standard-mode output.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] sb_std[$];
  bit            m_ovf, m_udf, m_std_valid;
  logic [DW-1:0] m_std_last;
  bit            mon_en = 1'b0;
  int            checks = 0;
  int            failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic chk_status(input string tag, input logic [4:0] cnt, input logic full,
                            input logic af, input logic empty, input logic ae,
                            input logic ovf, input logic udf);
    int n;
    n = mq.size();
    chk({tag, "_count"}, 32'(cnt), n);
    chk({tag, "_full"},  32'(full),  32'(n == DEPTH));
    chk({tag, "_afull"}, 32'(af),    32'(n >= AF));
    chk({tag, "_empty"}, 32'(empty), 32'(n == 0));
    chk({tag, "_aempty"},32'(ae),    32'(n <= AE));
    chk({tag, "_ovf"},   32'(ovf),   32'(m_ovf));
    chk({tag, "_udf"},   32'(udf),   32'(m_udf));
  endtask

  // Monitor: samples on the falling edge, half a cycle after the DUT updates.
  initial begin
    logic [DW-1:0] exp_d;
    forever begin
      @(negedge Clk);
      if (mon_en) begin
        chk_status("std", bus_std.Count_out, bus_std.Full_out, bus_std.AlmostFull_out,
                   bus_std.Empty_out, bus_std.AlmostEmpty_out,
                   bus_std.Overflow_out, bus_std.Underflow_out);
        chk_status("fwft", bus_fwft.Count_out, bus_fwft.Full_out, bus_fwft.AlmostFull_out,
                   bus_fwft.Empty_out, bus_fwft.AlmostEmpty_out,
                   bus_fwft.Overflow_out, bus_fwft.Underflow_out);
        chk("std_valid", 32'(bus_std.Valid_out), 32'(m_std_valid));
        if (bus_std.Valid_out === 1'b1) begin
          if (sb_std.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL std_data at %0t: actual=%0h required=no word pending",
                     $time, bus_std.Data_out);
          end else begin
            exp_d = sb_std.pop_front();
            chk("std_data", 32'(bus_std.Data_out), 32'(exp_d));
          end
        end else begin
          chk("std_hold", 32'(bus_std.Data_out), 32'(m_std_last));
        end
        chk("fwft_valid", 32'(bus_fwft.Valid_out), 32'(mq.size() != 0));
        if (mq.size() != 0) chk("fwft_data", 32'(bus_fwft.Data_out), 32'(mq[0]));
      end
    end
  end

  // One clock of stimulus: drive both DUTs and advance the model to the next edge.
  task automatic cycle(input bit clr, input bit wr, input bit rd, input logic [DW-1:0] din);
    bit full, empty, wa, ra;
    Clear_in            = clr;
    bus_std.WriteEn_in  = wr;
    bus_std.ReadEn_in   = rd;
    bus_std.Data_in     = din;
    bus_fwft.WriteEn_in = wr;
    bus_fwft.ReadEn_in  = rd;
    bus_fwft.Data_in    = din;
    if (clr) begin
      mq.delete();
      m_ovf       = 1'b0;
      m_udf       = 1'b0;
      m_std_valid = 1'b0;
      m_std_last  = '0;
      mon_en      = 1'b1;
    end else begin
      full  = (mq.size() == DEPTH);
      empty = (mq.size() == 0);
      wa    = wr && !full;
      ra    = rd && !empty;
      if (wr && full)  m_ovf = 1'b1;
      if (rd && empty) m_udf = 1'b1;
      m_std_valid = ra;
      if (ra) begin
        sb_std.push_back(mq[0]);
        m_std_last = mq[0];
        void'(mq.pop_front());
      end
      if (wa) mq.push_back(din);
    end
    @(negedge Clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] d;
    int wp, rp;
    cycle(1, 0, 0, 8'h00);
    cycle(1, 0, 0, 8'h00);
    cycle(0, 0, 0, 8'h00);

    // Fill 0x01..0x10, then one write too many.
    for (int i = 1; i <= 16; i++) cycle(0, 1, 0, 8'(i));
    cycle(0, 1, 0, 8'h11);
    cycle(0, 0, 0, 8'h00);

    // Drain in order, then one read too many.
    for (int i = 0; i < 16; i++) cycle(0, 0, 1, 8'h00);
    cycle(0, 0, 1, 8'h00);
    cycle(0, 0, 0, 8'h00);

    // Single word through the bypass path.
    cycle(1, 0, 0, 8'h00);
    cycle(0, 1, 0, 8'hA5);
    cycle(0, 0, 0, 8'h00);
    cycle(0, 0, 1, 8'h00);
    cycle(0, 0, 0, 8'h00);

    // Steady state at five words across pointer wrap.
    cycle(1, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 8'(8'h30 + i));
    for (int i = 0; i < 40; i++) cycle(0, 1, 1, 8'($urandom));

    // Full with simultaneous write and read: read wins, write dropped.
    for (int i = 0; i < 11; i++) cycle(0, 1, 0, 8'($urandom));
    cycle(0, 1, 1, 8'hEE);
    cycle(0, 0, 0, 8'h00);

    // Clear at nine words together with both requests.
    cycle(1, 0, 0, 8'h00);
    for (int i = 0; i < 9; i++) cycle(0, 1, 0, 8'(8'h90 + i));
    cycle(1, 1, 1, 8'h77);
    cycle(0, 0, 0, 8'h00);

    // Randomised traffic with write-heavy and read-heavy windows.
    for (int i = 0; i < 400; i++) begin
      wp = ((i / 50) % 2 == 0) ? 75 : 30;
      rp = 100 - wp;
      d  = 8'($urandom);
      cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < wp),
            ($urandom_range(0, 99) < rp), d);
    end
    cycle(0, 0, 0, 8'h00);
    cycle(0, 0, 0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
